// File: rtl/seq_serializer_if.sv
// Parallel-word handshake and serial bit stream between a word source and seq_serializer.
// master = word source / bit consumer, slave = serializer.
interface seq_serializer_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         X;
  logic         bit_valid;
  logic [3:0]   bit_idx;
  logic         word_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  X,
    input  bit_valid,
    input  bit_idx,
    input  word_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output X,
    output bit_valid,
    output bit_idx,
    output word_done
  );
endinterface

// File: rtl/seq_serializer.sv
// Serializes W-bit words onto X one bit per clock; first bit one cycle after accept.
// in_ready is high only in IDLE or on a word's last bit, so back-to-back words leave no gap.
module seq_serializer #(
  parameter int W          = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  seq_serializer_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(W - 1);

  state_e         state_q;
  logic [W-1:0]   shreg_q;
  logic [3:0]     idx_q;
  logic           x_q;
  logic           vld_q;
  logic           done_q;
  logic           rdy_q;

  logic           accept;
  logic           last_bit;
  logic [W-1:0]   shreg_shift_d;
  logic [3:0]     idx_inc_d;

  function automatic logic head_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  // in_data is only looked at when accept is true, so X/Z on an idle bus never reaches X
  assign accept   = bus.in_valid && rdy_q;
  assign last_bit = (state_q == SHIFT) && (idx_q == LAST_IDX);

  always_comb begin
    shreg_shift_d = '0;
    if (MSB_FIRST) begin
      shreg_shift_d = {shreg_q[W-2:0], 1'b0};
    end else begin
      shreg_shift_d = {1'b0, shreg_q[W-1:1]};
    end
    idx_inc_d = idx_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= 4'd0;
      x_q     <= IDLE_LEVEL;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SHIFT;
            shreg_q <= bus.in_data;
            idx_q   <= 4'd0;
            x_q     <= head_bit(bus.in_data);
            vld_q   <= 1'b1;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit && accept) begin
            // Reload on the last bit: the new word's first bit follows with no gap
            shreg_q <= bus.in_data;
            idx_q   <= 4'd0;
            x_q     <= head_bit(bus.in_data);
            vld_q   <= 1'b1;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
          end else if (last_bit) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= 4'd0;
            x_q     <= IDLE_LEVEL;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end else begin
            shreg_q <= shreg_shift_d;
            idx_q   <= idx_inc_d;
            x_q     <= head_bit(shreg_shift_d);
            vld_q   <= 1'b1;
            done_q  <= (idx_inc_d == LAST_IDX);
            rdy_q   <= (idx_inc_d == LAST_IDX);
          end
        end
      endcase
    end
  end

  assign bus.X         = x_q;
  assign bus.bit_valid = vld_q;
  assign bus.bit_idx   = idx_q;
  assign bus.word_done = done_q;
  assign bus.in_ready  = rdy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: one MSB-first and one LSB-first instance on a shared clock/reset.
module tb_seq_serializer;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  logic [3:0] hist;
  int   det_cnt;

  seq_serializer_if #(.W(8)) bm ();
  seq_serializer_if #(.W(8)) bl ();

  seq_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bm.slave)
  );

  seq_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for the downstream "0011" detector: counts matches on the observed X stream
  task automatic det_push(input logic b);
    hist = {hist[2:0], b};
    if (hist == 4'b0011) det_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bm.in_valid = 1'b0;
    bm.in_data  = 'x;
    bl.in_valid = 1'b0;
    bl.in_data  = 'x;
    step();
    step();
    reset = 1'b0;
    total++; if (bm.X !== 1'b1) $display("FAIL reset_x got=%b exp=1", bm.X); else passed++;
    total++; if (bm.bit_valid !== 1'b0) $display("FAIL reset_bit_valid got=%b exp=0", bm.bit_valid); else passed++;
    total++; if (bm.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bm.in_ready); else passed++;
    total++; if (bm.bit_idx !== 4'd0) $display("FAIL reset_bit_idx got=%0d exp=0", bm.bit_idx); else passed++;
    total++; if (bm.word_done !== 1'b0) $display("FAIL reset_word_done got=%b exp=0", bm.word_done); else passed++;
    total++; if (bl.X !== 1'b1 || bl.bit_valid !== 1'b0) $display("FAIL reset_lsb got=%b%b exp=10", bl.X, bl.bit_valid); else passed++;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    hist = 4'b1111;
    det_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      det_push(bm.X);
      if (bm.X !== 1'b1 || bm.bit_valid !== 1'b0 || bm.in_ready !== 1'b1 || bm.bit_idx !== 4'd0) bad++;
    end
    total++; if (bad != 0) $display("FAIL idle_outputs got=%0d bad cycles exp=0", bad); else passed++;
    total++; if (det_cnt != 0) $display("FAIL idle_detect got=%0d exp=0", det_cnt); else passed++;
  endtask

  task automatic test_single();
    logic [7:0] w;
    int bad_x, bad_idx, bad_ctl;
    w = 8'b0011_0011;
    bad_x = 0; bad_idx = 0; bad_ctl = 0;
    hist = 4'b1111;
    det_cnt = 0;
    bm.in_data  = w;
    bm.in_valid = 1'b1;
    step();
    bm.in_valid = 1'b0;
    bm.in_data  = 'x;
    for (int i = 0; i < 8; i++) begin
      if (bm.bit_valid === 1'b1) det_push(bm.X);
      if (bm.X !== w[7-i]) bad_x++;
      if (bm.bit_idx !== 4'(i)) bad_idx++;
      if (bm.bit_valid !== 1'b1 || bm.word_done !== (i == 7) || bm.in_ready !== (i == 7)) bad_ctl++;
      step();
    end
    total++; if (bad_x != 0) $display("FAIL single_x got=%0d bad bits exp=0", bad_x); else passed++;
    total++; if (bad_idx != 0) $display("FAIL single_bit_idx got=%0d bad exp=0", bad_idx); else passed++;
    total++; if (bad_ctl != 0) $display("FAIL single_ctl got=%0d bad exp=0", bad_ctl); else passed++;
    total++; if (det_cnt != 2) $display("FAIL single_detect got=%0d exp=2", det_cnt); else passed++;
    total++; if (bm.bit_valid !== 1'b0 || bm.X !== 1'b1 || bm.in_ready !== 1'b1 || bm.bit_idx !== 4'd0)
      $display("FAIL single_idle_after got=v%b x%b r%b i%0d exp=v0 x1 r1 i0", bm.bit_valid, bm.X, bm.in_ready, bm.bit_idx);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int bad_x, bad_idx, bad_vld, acc_cnt, acc_at;
    logic took;
    stream = 16'b1100_0011_0000_1111;
    bad_x = 0; bad_idx = 0; bad_vld = 0; acc_cnt = 0; acc_at = -1;
    bm.in_data  = 8'hC3;
    bm.in_valid = 1'b1;
    step();
    bm.in_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      if (bm.X !== stream[15-i]) bad_x++;
      if (bm.bit_idx !== 4'(i % 8)) bad_idx++;
      if (bm.bit_valid !== 1'b1) bad_vld++;
      took = bm.in_valid && bm.in_ready;
      if (took) begin
        acc_cnt++;
        acc_at = i;
      end
      step();
      if (took) begin
        bm.in_valid = 1'b0;
        bm.in_data  = 'x;
      end
    end
    total++; if (bad_x != 0) $display("FAIL b2b_x got=%0d bad bits exp=0", bad_x); else passed++;
    total++; if (bad_idx != 0) $display("FAIL b2b_bit_idx got=%0d bad exp=0", bad_idx); else passed++;
    total++; if (bad_vld != 0) $display("FAIL b2b_bit_valid got=%0d gaps exp=0", bad_vld); else passed++;
    total++; if (acc_cnt != 1 || acc_at != 7) $display("FAIL b2b_accepts got=%0d at %0d exp=1 at 7", acc_cnt, acc_at); else passed++;
    total++; if (bm.bit_valid !== 1'b0) $display("FAIL b2b_idle_after got=%b exp=0", bm.bit_valid); else passed++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    int bad;
    w = 8'b1100_0000;
    bad = 0;
    bl.in_data  = w;
    bl.in_valid = 1'b1;
    step();
    bl.in_valid = 1'b0;
    bl.in_data  = 'x;
    for (int i = 0; i < 8; i++) begin
      if (bl.X !== w[i] || bl.bit_valid !== 1'b1 || bl.bit_idx !== 4'(i)) bad++;
      step();
    end
    total++; if (bad != 0) $display("FAIL lsb_stream got=%0d bad bits exp=0", bad); else passed++;
    total++; if (bl.bit_valid !== 1'b0 || bl.X !== 1'b1) $display("FAIL lsb_idle_after got=v%b x%b exp=v0 x1", bl.bit_valid, bl.X); else passed++;
  endtask

  task automatic test_reset_mid_word();
    int bad;
    bad = 0;
    bm.in_data  = 8'hA5;
    bm.in_valid = 1'b1;
    step();
    bm.in_valid = 1'b0;
    bm.in_data  = 'x;
    step(); step(); step();
    total++; if (bm.bit_idx !== 4'd3 || bm.bit_valid !== 1'b1) $display("FAIL midrst_pre got=i%0d v%b exp=i3 v1", bm.bit_idx, bm.bit_valid); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (bm.bit_valid !== 1'b0 || bm.X !== 1'b1 || bm.in_ready !== 1'b1 || bm.bit_idx !== 4'd0 || bm.word_done !== 1'b0)
      $display("FAIL midrst_post got=v%b x%b r%b i%0d d%b exp=v0 x1 r1 i0 d0", bm.bit_valid, bm.X, bm.in_ready, bm.bit_idx, bm.word_done);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bm.bit_valid !== 1'b0 || bm.X !== 1'b1) bad++;
    end
    total++; if (bad != 0) $display("FAIL midrst_residue got=%0d cycles exp=0", bad); else passed++;
  endtask

  task automatic test_reset_collision();
    reset = 1'b1;
    bm.in_data  = 8'hF0;
    bm.in_valid = 1'b1;
    step();
    reset = 1'b0;
    total++; if (bm.bit_valid !== 1'b0 || bm.in_ready !== 1'b1 || bm.bit_idx !== 4'd0)
      $display("FAIL collide_no_shift got=v%b r%b i%0d exp=v0 r1 i0", bm.bit_valid, bm.in_ready, bm.bit_idx);
    else passed++;
    step();
    bm.in_valid = 1'b0;
    bm.in_data  = 'x;
    total++; if (bm.bit_valid !== 1'b1 || bm.bit_idx !== 4'd0 || bm.X !== 1'b1 || bm.in_ready !== 1'b0)
      $display("FAIL collide_accept_after got=v%b i%0d x%b r%b exp=v1 i0 x1 r0", bm.bit_valid, bm.bit_idx, bm.X, bm.in_ready);
    else passed++;
    repeat (8) step();
    total++; if (bm.bit_valid !== 1'b0 || bm.in_ready !== 1'b1) $display("FAIL collide_drain got=v%b r%b exp=v0 r1", bm.bit_valid, bm.in_ready); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    hist = 4'b1111;
    det_cnt = 0;
    reset = 1'b1;
    bm.in_valid = 1'b0;
    bm.in_data  = '0;
    bl.in_valid = 1'b0;
    bl.in_data  = '0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_reset_collision();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
